// File: rtl/riscv_aes_cipher_iter.sv
// Iterative AES-128 encryption engine.
// A single 128-bit state register and a single round-key register are advanced
// by UNROLL combinational rounds per clock. The key schedule is expanded on the
// fly alongside the data rounds, so no expanded-key storage is needed.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and payload stable until that edge. ready never
// depends on valid of the same port. out_valid never depends combinationally on
// out_ready.
module riscv_aes_cipher_iter #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    localparam int CYCLES = 10 / UNROLL;
    localparam logic [3:0] STEP     = 4'(UNROLL);
    // Round count already applied when the final RUN edge begins.
    localparam logic [3:0] LAST_RND = 4'(UNROLL * (CYCLES - 1));

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("riscv_aes_cipher_iter: UNROLL must be 1, 2, 5 or 10");
    end

    // AES S-box, byte 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    fsm_t         cur_st;
    fsm_t         nxt_st;
    logic [127:0] state;
    logic [127:0] round_key;
    logic [3:0]   rnd;
    logic [127:0] state_n;
    logic [127:0] round_key_n;
    logic         accept;
    logic         last_step;

    // Shared S-box cell: one lookup per byte, 16 per data round, 4 per key step.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // One key-schedule step: next round key from the current one.
    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // One cipher round; the final round omits MixColumns.
    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   sb [16];
        logic [127:0] sr;
        logic [127:0] mc;
        sr = '0;
        mc = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(s[127 - 8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127 - 8*(4*c + r) -: 8] = sb[4*((c + r) % 4) + r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[127 - 32*c -: 32] = mix_col(sr[127 - 32*c -: 32]);
        end
        return (last ? sr : mc) ^ rk;
    endfunction

    // Handshake qualifiers and the final-step flag.
    always_comb begin
        in_ready  = !rst && (cur_st == ST_IDLE || (cur_st == ST_DONE && out_ready));
        accept    = in_valid && in_ready;
        last_step = (cur_st == ST_RUN) && (rnd == LAST_RND);
        busy      = (cur_st == ST_RUN);
        dbg_state = cur_st;
    end

    // UNROLL chained rounds starting at round rnd+1.
    always_comb begin
        state_n     = state;
        round_key_n = round_key;
        for (int u = 0; u < UNROLL; u++) begin
            round_key_n = key_step(round_key_n, rcon_of(rnd + 4'(u + 1)));
            state_n     = enc_round(state_n, round_key_n, (rnd + 4'(u + 1)) == 4'd10);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_st <= ST_IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    // FSM next-state: DONE can hand off straight into RUN when a new block arrives.
    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            ST_IDLE: if (accept) nxt_st = ST_RUN;
            ST_RUN:  if (last_step) nxt_st = ST_DONE;
            ST_DONE: if (out_ready) nxt_st = accept ? ST_RUN : ST_IDLE;
            default: nxt_st = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, advance in RUN, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= '0;
            round_key <= '0;
            rnd       <= '0;
        end else if (accept) begin
            state     <= in_data ^ in_key;
            round_key <= in_key;
            rnd       <= '0;
        end else if (cur_st == ST_RUN) begin
            state     <= state_n;
            round_key <= round_key_n;
            rnd       <= rnd + STEP;
        end
    end

    // Output register: captured on the last RUN edge, held until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (last_step) begin
            out_valid <= 1'b1;
            out_data  <= state_n;
        end else if (cur_st == ST_DONE && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_aes_cipher_iter.sv
// Bench for riscv_aes_cipher_iter: four instances (UNROLL 1/2/5/10) on one clock,
// exercised one at a time. An independent AES model (S-box derived from GF(2^8)
// inversion, full key schedule up front) fills the expected queue on every input
// handshake; the monitor pops and compares on every output handshake.
module tb_riscv_aes_cipher_iter;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic         in_valid_a  [4];
    logic [127:0] in_data_a   [4];
    logic [127:0] in_key_a    [4];
    logic         out_ready_a [4];
    wire          in_ready_a  [4];
    wire          out_valid_a [4];
    wire  [127:0] out_data_a  [4];
    wire          busy_a      [4];
    wire  [1:0]   dbg_state_a [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int U = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
        riscv_aes_cipher_iter #(.UNROLL(U)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_data   (in_data_a[g]),
            .in_key    (in_key_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_data  (out_data_a[g]),
            .busy      (busy_a[g]),
            .dbg_state (dbg_state_a[g])
        );
    end

    function automatic int cycles_of(input int d);
        return (d == 0) ? 10 : (d == 1) ? 5 : (d == 2) ? 2 : 1;
    endfunction

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]}
                      ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ key[127 - 8*i -: 8];
        for (int rn = 1; rn <= 10; rn++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) s[4*c + r] = t[4*((c + r) % 4) + r];
            end
            if (rn < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int c = 0; c < 4; c++) begin
                tmp = w[4*rn + c];
                for (int r = 0; r < 4; r++) s[4*c + r] = s[4*c + r] ^ tmp[31 - 8*r -: 8];
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [127:0] exp_q [$];
    int acc_cyc  [4] = '{0, 0, 0, 0};
    int busy_cnt [4] = '{0, 0, 0, 0};
    bit prev_ov  [4] = '{0, 0, 0, 0};
    int n_pop = 0;

    // Samples 1 time unit after each falling edge; handshakes seen here complete
    // on the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                if (rst) begin
                    prev_ov[d]  = 1'b0;
                    busy_cnt[d] = 0;
                end else begin
                    if (out_valid_a[d] && !prev_ov[d]) begin
                        check_eq("latency", 128'(cyc - acc_cyc[d]), 128'(cycles_of(d)));
                        check_eq("busy_cycles", 128'(busy_cnt[d]), 128'(cycles_of(d)));
                    end
                    prev_ov[d] = out_valid_a[d];
                    if (busy_a[d]) busy_cnt[d]++;
                    if (out_valid_a[d] && out_ready_a[d]) begin
                        check_eq("sb_nonempty", 128'(exp_q.size() > 0), 128'(1));
                        if (exp_q.size() > 0) begin
                            check_eq("out_data", out_data_a[d], exp_q.pop_front());
                            n_pop++;
                        end
                    end
                    if (in_valid_a[d] && in_ready_a[d]) begin
                        exp_q.push_back(aes_ref(in_data_a[d], in_key_a[d]));
                        acc_cyc[d]  = cyc + 1;
                        busy_cnt[d] = 0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic send(input int d, input logic [127:0] pt, input logic [127:0] key);
        bit ok;
        ok = 1'b0;
        in_valid_a[d] = 1'b1;
        in_data_a[d]  = pt;
        in_key_a[d]   = key;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            ok = in_ready_a[d];
            @(negedge clk);
        end
        in_valid_a[d] = 1'b0;
        check_eq("send_accepted", 128'(ok), 128'(1));
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(negedge clk);
        check_eq("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] held;
        int           prev_acc;
        int           pops_before;
        bit           seen;

        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            in_valid_a[d]  = 1'b0;
            in_data_a[d]   = '0;
            in_key_a[d]    = '0;
            out_ready_a[d] = 1'b1;
        end
        build_sbox();
        check_eq("model_c1", aes_ref(C1_PT, C1_KEY), C1_CT);
        check_eq("model_b", aes_ref(B_PT, B_KEY), B_CT);

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check_eq("in_ready_in_rst", 128'(in_ready_a[0]), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            check_eq("rst_in_ready", 128'(in_ready_a[d]), 128'(1));
            check_eq("rst_out_valid", 128'(out_valid_a[d]), 128'(0));
            check_eq("rst_out_data", out_data_a[d], 128'(0));
            check_eq("rst_busy", 128'(busy_a[d]), 128'(0));
            check_eq("rst_state", 128'(dbg_state_a[d]), 128'(0));
        end
        @(negedge clk);

        // FIPS-197 C.1 on UNROLL=1.
        send(0, C1_PT, C1_KEY);
        drain(40);
        check_eq("c1_ct", out_data_a[0], C1_CT);

        // FIPS-197 B on UNROLL=2/5/10.
        for (int d = 1; d < 4; d++) begin
            send(d, B_PT, B_KEY);
            drain(40);
            check_eq("b_ct", out_data_a[d], B_CT);
        end

        // Back-pressure on UNROLL=1.
        out_ready_a[0] = 1'b0;
        send(0, rand128(), rand128());
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (out_valid_a[0]) seen = 1'b1;
            else @(negedge clk);
        end
        check_eq("bp_valid_rise", 128'(out_valid_a[0]), 128'(1));
        held = out_data_a[0];
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = rand128();
        in_key_a[0]   = rand128();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check_eq("bp_out_valid", 128'(out_valid_a[0]), 128'(1));
            check_eq("bp_out_data", out_data_a[0], held);
            check_eq("bp_in_ready", 128'(in_ready_a[0]), 128'(0));
        end
        check_eq("bp_pending", 128'(exp_q.size()), 128'(1));
        @(negedge clk);
        out_ready_a[0] = 1'b1;
        #1;
        check_eq("bp_release_in_ready", 128'(in_ready_a[0]), 128'(1));
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        #1;
        check_eq("bp_run_busy", 128'(busy_a[0]), 128'(1));
        check_eq("bp_run_out_valid", 128'(out_valid_a[0]), 128'(0));
        check_eq("bp_queue", 128'(exp_q.size()), 128'(1));
        @(negedge clk);
        drain(40);

        // Back-to-back streaming, 8 random blocks.
        pops_before = n_pop;
        prev_acc = 0;
        for (int k = 0; k < 8; k++) begin
            send(0, rand128(), rand128());
            if (k > 0) check_eq("stream_period", 128'(acc_cyc[0] - prev_acc), 128'(11));
            prev_acc = acc_cyc[0];
        end
        drain(40);
        check_eq("stream_count", 128'(n_pop - pops_before), 128'(8));

        // Input stability: inputs churn every cycle while the block runs.
        send(0, rand128(), rand128());
        for (int i = 0; i < 9; i++) begin
            in_data_a[0] = rand128();
            in_key_a[0]  = rand128();
            @(negedge clk);
        end
        drain(40);

        // Reset in the fourth RUN cycle.
        send(0, C1_PT, C1_KEY);
        repeat (3) @(negedge clk);
        check_eq("pre_rst_busy", 128'(busy_a[0]), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_state", 128'(dbg_state_a[0]), 128'(0));
        check_eq("mid_rst_out_valid", 128'(out_valid_a[0]), 128'(0));
        check_eq("mid_rst_out_data", out_data_a[0], 128'(0));
        check_eq("mid_rst_busy", 128'(busy_a[0]), 128'(0));
        exp_q.delete();
        repeat (15) @(negedge clk);
        check_eq("mid_rst_no_pulse", 128'(out_valid_a[0]), 128'(0));
        send(0, C1_PT, C1_KEY);
        drain(40);
        check_eq("post_rst_c1_ct", out_data_a[0], C1_CT);

        repeat (3) @(negedge clk);
        check_eq("final_queue", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
